prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: DEPTH, 4, instruction queue entries (power of two, >=2).
REQ-003 Parameter: RESET_PC, 32'h0, word address of the first fetch after reset.
REQ-004 Ports: clk  in  1  clock, all state updates on rising edge.
REQ-005 Ports: reset  in  1  synchronous active-high reset.
REQ-006 Ports: addr  out  32  word fetch address to memory_controller, registered.
REQ-007 Ports: wdata  out  32  tied 32'h0.
REQ-008 Ports: rdata  in  32  read data, valid the cycle after addr/trans are sampled.
REQ-009 Ports: abort  in  1  fetch fault, qualified with rdata.
REQ-010 Ports: write  out  1  tied 0; size  out  1  tied 1 (word); prot  out  2  tied 2'b10.
REQ-011 Ports: trans  out  2  2'b00 idle, 2'b10 nonsequential, 2'b11 sequential; registered.
REQ-012 Ports: instr  out  32, instr_pc  out  32, instr_abort  out  1: queue head contents.
REQ-013 Ports: instr_valid  out  1  queue non-empty; instr_ready  in  1  decode accepts head.
REQ-014 Ports: branch_valid  in  1, branch_target  in  32  redirect request from execute.

Function
REQ-015 SHALL keep fetch_pc; an issue edge registers addr<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^32 wrap).
REQ-016 SHALL issue only when count + in_flight < DEPTH; in_flight = unsquashed requests not yet written (0..2); pop in same cycle gives no credit.
REQ-017 trans SHALL be 2'b11 when issuing in the cycle directly after an issue, 2'b10 after an idle cycle, reset or branch, else 2'b00; addr holds when idle.
REQ-018 Request timing: trans/addr visible cycle C, rdata valid C+1, entry written at end of C+1, instr_valid high C+2 (issue-to-valid 2 cycles).
REQ-019 Queue SHALL be FIFO; head popped at edge when instr_valid && instr_ready; count never exceeds DEPTH.
REQ-020 Empty queue: instr_valid=0, instr=32'hE320F000 (AL NOP), instr_pc=0, instr_abort=0.
REQ-021 Write and pop in same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-022 branch_valid at edge SHALL: flush queue (count=0), squash all in-flight requests (their rdata never written), addr<=branch_target, trans<=2'b10, fetch_pc<=branch_target+1.
REQ-023 Branch SHALL take priority over pop and over any simultaneous write; instr_ready ignored that cycle.
REQ-024 First post-branch instruction SHALL reach instr_valid 3 cycles after branch_valid, instr_pc=branch_target.

Reset
REQ-025 While reset high: addr=RESET_PC, trans=2'b00, fetch_pc=RESET_PC, count=0, pointers 0, in-flight tags cleared, halted flag 0.
REQ-026 First edge with reset low SHALL issue RESET_PC with trans=2'b10.
REQ-027 Reset mid-operation SHALL discard the queue and any response arriving in the cycle after reset.

Configuration
REQ-028 Macro PREFETCH_ABORT_EN defined: abort stored per entry and driven on instr_abort at head; after an aborted entry is written, issuing stops (trans=2'b00) until branch_valid or reset.
REQ-029 Macro undefined: abort ignored, instr_abort tied 0, fetching continues regardless.

Verification
REQ-030 Reset release, instr_ready=1, memory word n = n: trans 10,11,11...; instr_pc 0,1,2 on consecutive cycles from cycle 2.
REQ-031 instr_ready=0 with DEPTH=4: exactly 4 issues, then trans=2'b00, count=4; ready=1 resumes with trans=2'b10.
REQ-032 branch_valid with target 32'h100 while 2 requests in flight and queue 3 deep: next cycle addr=32'h100 trans=2'b10, no stale instr delivered, instr_pc=32'h100 3 cycles later.
REQ-033 Branch and pop same cycle with full queue: queue empty next cycle, instr=32'hE320F000, instr_valid=0.
REQ-034 PREFETCH_ABORT_EN defined, abort=1 on address 5: entry 5 has instr_abort=1, no further issues until branch to 32'h0 restarts fetch.
REQ-035 Reset asserted with 2 in flight, released: first instr_pc=RESET_PC, no pre-reset data seen.

Source files
------------

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues sequential word fetches into a DEPTH-entry FIFO and flushes on branch.
// Optional feature macro PREFETCH_ABORT_EN: keep per-entry fetch aborts and halt fetching after an abort.
`timescale 1ns/1ps
module prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        abort,
  output logic        write,
  output logic        size,
  output logic [1:0]  prot,
  output logic [1:0]  trans,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_abort,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_valid,
  input  logic [31:0] branch_target
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [1:0]  TR_IDLE = 2'b00;
  localparam logic [1:0]  TR_NSEQ = 2'b10;
  localparam logic [1:0]  TR_SEQ  = 2'b11;
  localparam logic [31:0] NOP     = 32'hE320F000;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_addr_p0;
  logic [1:0]    r_trans_p0;
  logic          r_vld_p1;
  logic [31:0]   r_pc_p1;
  logic [31:0]   r_q_data [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_halt;

  logic          w_vld_p0;
  logic          w_wr;
  logic          w_pop;
  logic          w_nempty;
  logic          w_halt_now;
  logic          w_issue;
  logic [CW:0]   w_occ;

  assign w_vld_p0 = (r_trans_p0 != TR_IDLE);
  assign w_wr     = r_vld_p1;
  assign w_nempty = (r_count != '0);
  assign w_pop    = w_nempty && instr_ready;
  // Queued entries plus both outstanding request stages; a same-cycle pop earns no credit.
  assign w_occ    = {1'b0, r_count} + {{CW{1'b0}}, w_vld_p0} + {{CW{1'b0}}, r_vld_p1};
  assign w_issue  = (w_occ < (CW+1)'(DEPTH)) && !r_halt && !w_halt_now;

`ifdef PREFETCH_ABORT_EN
  logic r_q_abt [DEPTH];
  assign w_halt_now  = w_wr && abort;
  assign instr_abort = w_nempty && r_q_abt[r_rptr];
`else
  logic w_unused_abort;
  assign w_unused_abort = abort;
  assign w_halt_now     = 1'b0;
  assign instr_abort    = 1'b0;
`endif

  // Stage p0 -> p1: response for the request visible last cycle is on rdata now
  always_ff @(posedge clk) begin
    r_pc_p1 <= r_addr_p0;
    if (w_wr) begin
      r_q_data[r_wptr] <= rdata;
      r_q_pc[r_wptr]   <= r_pc_p1;
`ifdef PREFETCH_ABORT_EN
      r_q_abt[r_wptr]  <= abort;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_p0  <= RESET_PC;
      r_trans_p0 <= TR_IDLE;
      r_fetch_pc <= RESET_PC;
      r_vld_p1   <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_halt     <= 1'b0;
    end else if (branch_valid) begin
      // Redirect squashes both request stages and drops any write or pop this cycle
      r_addr_p0  <= branch_target;
      r_trans_p0 <= TR_NSEQ;
      r_fetch_pc <= branch_target + 32'd1;
      r_vld_p1   <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_halt     <= 1'b0;
    end else begin
      if (w_issue) begin
        r_addr_p0  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd1;
        r_trans_p0 <= w_vld_p0 ? TR_SEQ : TR_NSEQ;
      end else begin
        r_trans_p0 <= TR_IDLE;
      end
      r_vld_p1 <= w_vld_p0;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_wr} - {{PW{1'b0}}, w_pop};
      r_halt  <= r_halt || w_halt_now;
    end
  end

  assign addr        = r_addr_p0;
  assign trans       = r_trans_p0;
  assign wdata       = 32'h0;
  assign write       = 1'b0;
  assign size        = 1'b1;
  assign prot        = 2'b10;
  assign instr_valid = w_nempty;
  assign instr       = w_nempty ? r_q_data[r_rptr] : NOP;
  assign instr_pc    = w_nempty ? r_q_pc[r_rptr]   : 32'h0;

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed and randomized steps checked each cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_prefetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0040;
  localparam logic [31:0] NOP   = 32'hE320F000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        abort, write, size;
  logic [1:0]  prot, trans;
  logic [31:0] instr, instr_pc;
  logic        instr_abort, instr_valid, instr_ready;
  logic        branch_valid;
  logic [31:0] branch_target;

  always #5 clk = ~clk;

  prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(rst), .addr(addr), .wdata(wdata), .rdata(rdata), .abort(abort),
    .write(write), .size(size), .prot(prot), .trans(trans), .instr(instr),
    .instr_pc(instr_pc), .instr_abort(instr_abort), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_valid(branch_valid), .branch_target(branch_target)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct { logic [31:0] data; logic [31:0] pc; logic abt; } ent_t;
  typedef struct { logic [31:0] pc; int due; } req_t;
  ent_t        m_q[$];
  req_t        m_fl[$];
  logic [31:0] m_addr, m_fetch;
  logic [1:0]  m_trans;
  logic        m_halt;
  logic        prev_act;
  logic [31:0] prev_addr;
  logic        abt_en = 1'b0;
  logic [31:0] abt_addr = 32'd5;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AA5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: requests complete two edges after issue; queue holds delivered words in order.
  function automatic void model_edge();
    int   n_before;
    logic popping;
    logic wrote_abt;
    ent_t e;
    req_t r;
    edge_n++;
    if (rst) begin
      m_q.delete(); m_fl.delete();
      m_addr = RPC; m_fetch = RPC; m_trans = 2'b00; m_halt = 1'b0;
    end else if (branch_valid) begin
      m_q.delete(); m_fl.delete();
      m_addr = branch_target; m_fetch = branch_target + 32'd1; m_trans = 2'b10; m_halt = 1'b0;
      r.pc = branch_target; r.due = edge_n + 2;
      m_fl.push_back(r);
    end else begin
      n_before  = m_q.size() + m_fl.size();
      popping   = instr_ready && (m_q.size() > 0);
      wrote_abt = 1'b0;
      while (m_fl.size() > 0 && m_fl[0].due == edge_n) begin
        r = m_fl[0];
        m_fl.delete(0);
        e.data = memfn(r.pc);
        e.pc   = r.pc;
`ifdef PREFETCH_ABORT_EN
        e.abt  = abt_en && (r.pc == abt_addr);
`else
        e.abt  = 1'b0;
`endif
        wrote_abt = wrote_abt | e.abt;
        m_q.push_back(e);
      end
      if (popping) m_q.delete(0);
      if (n_before < DEPTH && !m_halt && !wrote_abt) begin
        m_trans = (m_trans != 2'b00) ? 2'b11 : 2'b10;
        m_addr  = m_fetch;
        r.pc = m_fetch; r.due = edge_n + 2;
        m_fl.push_back(r);
        m_fetch = m_fetch + 32'd1;
      end else begin
        m_trans = 2'b00;
      end
      m_halt = m_halt | wrote_abt;
    end
  endfunction

  // Memory side: answers the request seen last cycle; idle cycles carry junk.
  task automatic respond();
    rdata = prev_act ? memfn(prev_addr) : $urandom;
`ifdef PREFETCH_ABORT_EN
    abort = prev_act && abt_en && (prev_addr == abt_addr);
`else
    abort = 1'($urandom_range(0, 1));
`endif
    prev_act  = (trans != 2'b00);
    prev_addr = addr;
  endtask

  task automatic compare();
    logic ev;
    ev = (m_q.size() > 0);
    chk("addr", addr, m_addr);
    chk("trans", {30'b0, trans}, {30'b0, m_trans});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
    chk("instr", instr, ev ? m_q[0].data : NOP);
    chk("instr_pc", instr_pc, ev ? m_q[0].pc : 32'h0);
    chk("instr_abort", {31'b0, instr_abort}, {31'b0, ev ? m_q[0].abt : 1'b0});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    respond();
    compare();
  endtask

  task automatic do_branch(input logic [31:0] tgt);
    branch_valid = 1'b1; branch_target = tgt;
    tick();
    branch_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b0; branch_valid = 1'b0; branch_target = 32'h0;
    rdata = 32'h0; abort = 1'b0; prev_act = 1'b0; prev_addr = 32'h0;
    m_addr = RPC; m_fetch = RPC; m_trans = 2'b00; m_halt = 1'b0;

    repeat (3) tick();
    chk("wdata", wdata, 32'h0);
    chk("write", {31'b0, write}, 32'h0);
    chk("size", {31'b0, size}, 32'h1);
    chk("prot", {30'b0, prot}, 32'h2);

    // Streaming from reset with decode always ready
    rst = 1'b0; instr_ready = 1'b1;
    repeat (12) tick();

    // Back-pressure until full, then resume
    instr_ready = 1'b0; repeat (10) tick();
    instr_ready = 1'b1; repeat (6) tick();

    // Branch with requests in flight and a partly filled queue
    instr_ready = 1'b0; repeat (4) tick();
    do_branch(32'h100);
    instr_ready = 1'b1; repeat (6) tick();

    // Branch coinciding with a pop on a full queue
    instr_ready = 1'b0; repeat (10) tick();
    instr_ready = 1'b1;
    do_branch(32'h200);
    repeat (5) tick();

    // Fetch address wrap
    do_branch(32'hFFFF_FFFE);
    repeat (8) tick();

    // Randomized ready/branch traffic
    for (int i = 0; i < 400; i++) begin
      instr_ready  = ($urandom_range(0, 3) != 0);
      branch_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           branch_target = $urandom;
      tick();
    end
    branch_valid = 1'b0;

    // Reset with requests outstanding
    instr_ready = 1'b1; repeat (3) tick();
    rst = 1'b1; tick();
    rst = 1'b0; repeat (8) tick();

`ifdef PREFETCH_ABORT_EN
    // Abort at word 5 halts fetching until a branch restarts it
    abt_en = 1'b1; abt_addr = 32'd5;
    instr_ready = 1'b0;
    do_branch(32'h0);
    repeat (6) tick();
    instr_ready = 1'b1;
    repeat (14) tick();
    abt_en = 1'b0;
    do_branch(32'h0);
    repeat (10) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
